otter_mem_arbiter: RTL

Shares the single data-capable OTTER memory port between the instruction-fetch requester and the MEM-stage load/store requester. It sits between the pipeline and the Memory block and grants at most one access per eligible cycle. It tracks outstanding reads for a configurable read latency and returns each response only to its owner. Data accesses win by default; a streak counter bounds fetch starvation.

---
 rtl/otter_arb_pkg.sv | 20 ++
 rtl/otter_mem_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/otter_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// otter_arb_pkg : shared types for the OTTER memory-port arbiter (rev 1.0)
// ------------------------------------------------------------------------
package otter_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_t;

   typedef enum logic [0:0] {
      OWN_IF   = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_t;

   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

endpackage
`default_nettype wire

// File: rtl/otter_mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// otter_mem_arbiter : fetch / load-store arbiter for the shared OTTER memory port (rev 1.0)
// ------------------------------------------------------------------------
module otter_mem_arbiter
   import otter_arb_pkg::*;
#(
   parameter int RD_LATENCY   = 1,
   parameter int MAX_D_STREAK = 4
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   input  logic        d_sign,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_rden,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [1:0]  mem_size,
   output logic        mem_sign,
   input  logic [31:0] mem_dout
);

   localparam logic [1:0] LAT_M1     = 2'(RD_LATENCY - 1);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   arb_state_t state, state_nxt;
   arb_owner_t owner, owner_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [3:0] streak, streak_nxt;
   logic       kill, kill_nxt;
   logic       eligible, resp, gnt_if, gnt_d;

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      cnt_nxt    = cnt;
      kill_nxt   = kill;
      streak_nxt = streak;
      mem_rden   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'd0;
      mem_din    = 32'd0;
      mem_size   = 2'b00;
      mem_sign   = 1'b0;
      if_rdata   = mem_dout;
      d_rdata    = mem_dout;

      // Outputs are forced low while reset is asserted, independent of the clock.
      eligible  = rst_n && ((state == IDLE) || (cnt == 2'd0));
      resp      = rst_n && (state == WAIT) && (cnt == 2'd0);
      gnt_d     = eligible && d_req && (!if_req || (streak != STREAK_MAX));
      gnt_if    = eligible && if_req && !gnt_d;
      if_gnt    = gnt_if;
      d_gnt     = gnt_d;
      d_rvalid  = resp && (owner == OWN_DATA);
      if_rvalid = resp && (owner == OWN_IF) && !kill && !if_flush;

      if (state == WAIT) begin
         if (cnt == 2'd0) state_nxt = IDLE;
         else             cnt_nxt   = cnt - 2'd1;
         if ((owner == OWN_IF) && if_flush) kill_nxt = 1'b1;
      end

      if (gnt_if) begin
         mem_rden  = 1'b1;
         mem_addr  = if_addr;
         mem_size  = MEM_SIZE_WORD;
         state_nxt = WAIT;
         cnt_nxt   = LAT_M1;
         owner_nxt = OWN_IF;
         kill_nxt  = if_flush;
      end else if (gnt_d) begin
         mem_rden = !d_we;
         mem_we   = d_we;
         mem_addr = d_addr;
         mem_din  = d_wdata;
         mem_size = d_size;
         mem_sign = d_sign;
         if (!d_we) begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
            owner_nxt = OWN_DATA;
            kill_nxt  = 1'b0;
         end
      end

      if (!if_req || gnt_if)            streak_nxt = 4'd0;
      else if (gnt_d && streak != 4'hF) streak_nxt = streak + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         owner  <= OWN_IF;
         cnt    <= 2'd0;
         kill   <= 1'b0;
         streak <= 4'd0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         cnt    <= cnt_nxt;
         kill   <= kill_nxt;
         streak <= streak_nxt;
      end
   end

endmodule
`default_nettype wire
